// File: rtl/sfp_channel_packetizer.sv
// sfp_channel_packetizer
//
// Round-robin packetizer. It arbitrates N_CH AXI-Stream input channels and sends one whole
// frame at a time onto a single TX AXI-Stream towards the 10G MAC. Each frame is preceded by a
// header word that carries 8'hA5, the channel ID and that channel's sequence number. Frames
// longer than MAX_LEN payload words are cut short. The cut frame is ended with TLAST and TUSER
// set, and the rest of the input frame is read and thrown away.
//
// Optional build macro: SFP_PACKETIZER_TRAILER_EN. When it is defined, each frame closes with
// a trailer word instead of TLAST on the last payload word. The trailer carries 8'h5A, the
// channel ID, the payload word count and the truncated flag.
//
// Ports:
//   TX_ACLK, TX_RESET             clock; synchronous active-high reset
//   S_AXIS_TDATA/TVALID/TLAST/    per-channel input streams; channel i uses
//   TUSER/TREADY                  TDATA[i*DATA_WIDTH +: DATA_WIDTH]
//   TX_M_AXIS_TDATA/TKEEP/TVALID/ output stream to the MAC; TKEEP is always all ones
//   TLAST/TUSER/TREADY
//   BUSY                          high whenever a frame is in flight
//   TRUNC_CNT                     saturating count of truncated frames

module sfp_channel_packetizer #(
  parameter int unsigned N_CH       = 8,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned MAX_LEN    = 256,
  parameter int unsigned SEQ_WIDTH  = 16
) (
  input  logic                       TX_ACLK,
  input  logic                       TX_RESET,
  input  logic [N_CH*DATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic [N_CH-1:0]            S_AXIS_TVALID,
  input  logic [N_CH-1:0]            S_AXIS_TLAST,
  input  logic [N_CH-1:0]            S_AXIS_TUSER,
  output logic [N_CH-1:0]            S_AXIS_TREADY,
  output logic [DATA_WIDTH-1:0]      TX_M_AXIS_TDATA,
  output logic [DATA_WIDTH/8-1:0]    TX_M_AXIS_TKEEP,
  output logic                       TX_M_AXIS_TVALID,
  output logic                       TX_M_AXIS_TLAST,
  output logic                       TX_M_AXIS_TUSER,
  input  logic                       TX_M_AXIS_TREADY,
  output logic                       BUSY,
  output logic [15:0]                TRUNC_CNT
);

  localparam int unsigned ChW = (N_CH > 1) ? $clog2(N_CH) : 1;

`ifdef SFP_PACKETIZER_TRAILER_EN
  typedef enum logic [2:0] {StIdle, StHeader, StPayload, StDrop, StTrailer} state_e;
`else
  typedef enum logic [1:0] {StIdle, StHeader, StPayload, StDrop} state_e;
`endif

  state_e                 state_q, state_d;
  logic [ChW-1:0]         grant_q, grant_d;
  logic [ChW-1:0]         ptr_q, ptr_d;
  logic [SEQ_WIDTH-1:0]   seq_q [N_CH];
  logic [SEQ_WIDTH-1:0]   seq_d [N_CH];
  logic [15:0]            wcnt_q, wcnt_d;
  logic [15:0]            trunc_cnt_q, trunc_cnt_d;
`ifdef SFP_PACKETIZER_TRAILER_EN
  logic                   trunc_flag_q, trunc_flag_d;
  logic                   err_q, err_d;
`endif

  // Unpack the input data bus so the granted channel can be selected by index.
  logic [DATA_WIDTH-1:0] ch_data [N_CH];
  for (genvar i = 0; i < N_CH; i++) begin : g_unpack
    assign ch_data[i] = S_AXIS_TDATA[i*DATA_WIDTH +: DATA_WIDTH];
  end

  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_valid, sel_last, sel_user, at_max;
  assign sel_data  = ch_data[grant_q];
  assign sel_valid = S_AXIS_TVALID[grant_q];
  assign sel_last  = S_AXIS_TLAST[grant_q];
  assign sel_user  = S_AXIS_TUSER[grant_q];
  // The word now on offer would be payload word number MAX_LEN.
  assign at_max    = (wcnt_q == 16'(MAX_LEN - 1));

  // Search from the channel after the last grant, wrapping, so each channel waits at most
  // N_CH-1 frames.
  logic [ChW-1:0] arb_ch;
  logic           arb_hit;
  int unsigned    arb_idx;
  always_comb begin
    arb_hit = 1'b0;
    arb_ch  = ptr_q;
    arb_idx = 0;
    for (int unsigned k = 1; k <= N_CH; k++) begin
      arb_idx = (32'(ptr_q) + k) % N_CH;
      if (!arb_hit && S_AXIS_TVALID[ChW'(arb_idx)]) begin
        arb_hit = 1'b1;
        arb_ch  = ChW'(arb_idx);
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    ptr_d            = ptr_q;
    seq_d            = seq_q;
    wcnt_d           = wcnt_q;
    trunc_cnt_d      = trunc_cnt_q;
`ifdef SFP_PACKETIZER_TRAILER_EN
    trunc_flag_d     = trunc_flag_q;
    err_d            = err_q;
`endif
    TX_M_AXIS_TDATA  = '0;
    TX_M_AXIS_TVALID = 1'b0;
    TX_M_AXIS_TLAST  = 1'b0;
    TX_M_AXIS_TUSER  = 1'b0;
    S_AXIS_TREADY    = '0;

    unique case (state_q)
      StIdle: begin
        if (arb_hit) begin
          grant_d = arb_ch;
          ptr_d   = arb_ch;
          state_d = StHeader;
        end
      end

      StHeader: begin
        TX_M_AXIS_TVALID        = 1'b1;
        TX_M_AXIS_TDATA[63:56]  = 8'hA5;
        TX_M_AXIS_TDATA[55:48]  = 8'(grant_q);
        TX_M_AXIS_TDATA[47:32]  = 16'(seq_q[grant_q]);
        if (TX_M_AXIS_TREADY) begin
          seq_d[grant_q] = seq_q[grant_q] + SEQ_WIDTH'(1);
          wcnt_d         = '0;
`ifdef SFP_PACKETIZER_TRAILER_EN
          trunc_flag_d   = 1'b0;
          err_d          = 1'b0;
`endif
          state_d        = StPayload;
        end
      end

      StPayload: begin
        TX_M_AXIS_TDATA          = sel_data;
        TX_M_AXIS_TVALID         = sel_valid;
        S_AXIS_TREADY[grant_q]   = TX_M_AXIS_TREADY;
`ifndef SFP_PACKETIZER_TRAILER_EN
        // A real TLAST on word MAX_LEN takes priority, so that frame is not marked truncated.
        if (sel_last) begin
          TX_M_AXIS_TLAST = 1'b1;
          TX_M_AXIS_TUSER = sel_user;
        end else if (at_max) begin
          TX_M_AXIS_TLAST = 1'b1;
          TX_M_AXIS_TUSER = 1'b1;
        end
`endif
        if (sel_valid && TX_M_AXIS_TREADY) begin
          wcnt_d = wcnt_q + 16'd1;
          if (sel_last) begin
`ifdef SFP_PACKETIZER_TRAILER_EN
            err_d   = sel_user;
            state_d = StTrailer;
`else
            state_d = StIdle;
`endif
          end else if (at_max) begin
            if (trunc_cnt_q != 16'hFFFF) trunc_cnt_d = trunc_cnt_q + 16'd1;
`ifdef SFP_PACKETIZER_TRAILER_EN
            trunc_flag_d = 1'b1;
`endif
            state_d = StDrop;
          end
        end
      end

      StDrop: begin
        S_AXIS_TREADY[grant_q] = 1'b1;
        if (sel_valid && sel_last) begin
`ifdef SFP_PACKETIZER_TRAILER_EN
          err_d   = sel_user;
          state_d = StTrailer;
`else
          state_d = StIdle;
`endif
        end
      end

`ifdef SFP_PACKETIZER_TRAILER_EN
      StTrailer: begin
        TX_M_AXIS_TVALID       = 1'b1;
        TX_M_AXIS_TLAST        = 1'b1;
        TX_M_AXIS_TDATA[63:56] = 8'h5A;
        TX_M_AXIS_TDATA[55:48] = 8'(grant_q);
        TX_M_AXIS_TDATA[47:32] = wcnt_q;
        TX_M_AXIS_TDATA[0]     = trunc_flag_q;
        TX_M_AXIS_TUSER        = err_q | trunc_flag_q;
        if (TX_M_AXIS_TREADY) state_d = StIdle;
      end
`endif

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge TX_ACLK) begin
    if (TX_RESET) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      ptr_q       <= ChW'(N_CH - 1);
      for (int i = 0; i < N_CH; i++) seq_q[i] <= '0;
      wcnt_q      <= '0;
      trunc_cnt_q <= '0;
`ifdef SFP_PACKETIZER_TRAILER_EN
      trunc_flag_q <= 1'b0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      seq_q       <= seq_d;
      wcnt_q      <= wcnt_d;
      trunc_cnt_q <= trunc_cnt_d;
`ifdef SFP_PACKETIZER_TRAILER_EN
      trunc_flag_q <= trunc_flag_d;
      err_q        <= err_d;
`endif
    end
  end

  assign TX_M_AXIS_TKEEP = '1;
  assign BUSY            = (state_q != StIdle);
  assign TRUNC_CNT       = trunc_cnt_q;

endmodule

// File: tb/tb_sfp_channel_packetizer.sv
// Testbench for sfp_channel_packetizer. Input queues feed the DUT. A frame-level model follows
// the same input streams and predicts what the output must be on every cycle. Directed
// scenarios also log the output words and check them against hand-computed values.
module tb_sfp_channel_packetizer;
  localparam int NCH = 8;
  localparam int DW  = 64;
  localparam int ML  = 4;
  localparam int SW  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH*DW-1:0] s_tdata = '0;
  logic [NCH-1:0]    s_tvalid = '0, s_tlast = '0, s_tuser = '0, s_tready;
  logic [DW-1:0]     m_tdata;
  logic [DW/8-1:0]   m_tkeep;
  logic              m_tvalid, m_tlast, m_tuser, busy;
  logic              m_tready = 1'b0;
  logic [15:0]       trunc_cnt;

  always #5 clk = ~clk;

  sfp_channel_packetizer #(
    .N_CH(NCH), .DATA_WIDTH(DW), .MAX_LEN(ML), .SEQ_WIDTH(SW)
  ) dut (
    .TX_ACLK(clk), .TX_RESET(rst),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TVALID(s_tvalid), .S_AXIS_TLAST(s_tlast),
    .S_AXIS_TUSER(s_tuser), .S_AXIS_TREADY(s_tready),
    .TX_M_AXIS_TDATA(m_tdata), .TX_M_AXIS_TKEEP(m_tkeep), .TX_M_AXIS_TVALID(m_tvalid),
    .TX_M_AXIS_TLAST(m_tlast), .TX_M_AXIS_TUSER(m_tuser), .TX_M_AXIS_TREADY(m_tready),
    .BUSY(busy), .TRUNC_CNT(trunc_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Source queues (what the bench drives) and model copies (what the model consumes).
  logic [DW-1:0] sq_d [NCH][$];
  bit            sq_l [NCH][$];
  bit            sq_u [NCH][$];
  logic [DW-1:0] md   [NCH][$];
  bit            ml   [NCH][$];
  bit            mu   [NCH][$];
  logic [NCH-1:0] hs_vec = '0;
  int rdy_mode = 0;
  int vld_pct  = 100;

  // Output words accepted by the MAC, for the directed checks.
  logic [DW-1:0] log_d [$];
  bit            log_l [$];
  bit            log_u [$];

  task automatic push_word(input int ch, input logic [DW-1:0] d, input bit l, input bit u);
    sq_d[ch].push_back(d); sq_l[ch].push_back(l); sq_u[ch].push_back(u);
    md[ch].push_back(d);   ml[ch].push_back(l);   mu[ch].push_back(u);
  endtask

  task automatic push_frame(input int ch, input int len);
    for (int i = 0; i < len; i++)
      push_word(ch, {$urandom, $urandom}, (i == len - 1), 1'($urandom_range(0, 1)));
  endtask

  // Driver: a source holds TVALID and its word until the word is handshaken.
  always @(posedge clk) begin
    #1;
    for (int c = 0; c < NCH; c++) begin
      if (hs_vec[c] && sq_d[c].size() > 0) begin
        void'(sq_d[c].pop_front()); void'(sq_l[c].pop_front()); void'(sq_u[c].pop_front());
        s_tvalid[c] = 1'b0;
      end
      if (sq_d[c].size() == 0) begin
        s_tvalid[c] = 1'b0;
      end else begin
        if (!s_tvalid[c]) s_tvalid[c] = ($urandom_range(0, 99) < vld_pct);
        s_tdata[c*DW +: DW] = sq_d[c][0];
        s_tlast[c]          = sq_l[c][0];
        s_tuser[c]          = sq_u[c][0];
      end
    end
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ~m_tready;
      default: m_tready = 1'($urandom_range(0, 1));
    endcase
  end

  // Frame-level model and the per-cycle compare.
  bit            m_act, m_hdr, m_drop, prev_stall;
  int            m_g, m_ptr, m_nout;
  int            m_seq [NCH];
  logic [15:0]   m_trunc;
  logic [DW-1:0] prev_data;

  always @(negedge clk) begin
    bit found, exp_last, exp_trunc;
    hs_vec = '0;
    if (rst) begin
      m_act = 0; m_hdr = 0; m_drop = 0; m_ptr = NCH - 1; m_g = 0; m_nout = 0;
      m_trunc = '0; prev_stall = 0;
      for (int c = 0; c < NCH; c++) begin
        m_seq[c] = 0; md[c].delete(); ml[c].delete(); mu[c].delete();
      end
    end else begin
      chk("tkeep", m_tkeep, 8'hFF);
      chk("trunc_cnt", trunc_cnt, m_trunc);
      if (prev_stall) begin
        chk("stall_valid", m_tvalid, 1'b1);
        chk("stall_data", m_tdata, prev_data);
      end
      if (!m_act) begin
        chk("idle_busy", busy, 1'b0);
        chk("idle_valid", m_tvalid, 1'b0);
        chk("idle_tready", s_tready, '0);
        chk("idle_tdata", m_tdata, '0);
        chk("idle_tlast", m_tlast, 1'b0);
        chk("idle_tuser", m_tuser, 1'b0);
        found = 0;
        for (int k = 1; k <= NCH; k++) begin
          if (!found && s_tvalid[(m_ptr + k) % NCH]) begin
            found = 1; m_g = (m_ptr + k) % NCH;
          end
        end
        if (found) begin
          m_ptr = m_g; m_act = 1; m_hdr = 1; m_drop = 0; m_nout = 0;
        end
      end else begin
        chk("busy", busy, 1'b1);
        if (m_hdr) begin
          chk("hdr_valid", m_tvalid, 1'b1);
          chk("hdr_data", m_tdata, {8'hA5, 8'(m_g), 16'(m_seq[m_g]), 32'h0});
          chk("hdr_last", m_tlast, 1'b0);
          chk("hdr_tready", s_tready, '0);
          if (m_tready) begin
            log_d.push_back(m_tdata); log_l.push_back(m_tlast); log_u.push_back(m_tuser);
            m_seq[m_g] = (m_seq[m_g] + 1) % (1 << SW);
            m_hdr = 0;
          end
        end else if (!m_drop) begin
          chk("pl_tready", s_tready, m_tready ? (1 << m_g) : 0);
          chk("pl_valid", m_tvalid, s_tvalid[m_g]);
          if (s_tvalid[m_g]) begin
            if (md[m_g].size() == 0) begin
              n_cmp++; n_err++;
              $display("FAIL model_underrun: channel %0d valid with no queued word", m_g);
            end else begin
              exp_last  = ml[m_g][0];
              exp_trunc = !exp_last && (m_nout == ML - 1);
              chk("pl_data", m_tdata, md[m_g][0]);
              chk("pl_last", m_tlast, exp_last || exp_trunc);
              if (exp_last || exp_trunc) chk("pl_user", m_tuser, exp_trunc ? 1'b1 : mu[m_g][0]);
              if (m_tready) begin
                log_d.push_back(m_tdata); log_l.push_back(m_tlast); log_u.push_back(m_tuser);
                hs_vec[m_g] = 1'b1;
                void'(md[m_g].pop_front()); void'(ml[m_g].pop_front()); void'(mu[m_g].pop_front());
                m_nout++;
                if (exp_last) m_act = 0;
                else if (exp_trunc) begin
                  m_drop = 1;
                  if (m_trunc != 16'hFFFF) m_trunc = m_trunc + 16'd1;
                end
              end
            end
          end
        end else begin
          chk("drop_valid", m_tvalid, 1'b0);
          chk("drop_tready", s_tready, 1 << m_g);
          if (s_tvalid[m_g] && md[m_g].size() > 0) begin
            hs_vec[m_g] = 1'b1;
            if (ml[m_g][0]) m_act = 0;
            void'(md[m_g].pop_front()); void'(ml[m_g].pop_front()); void'(mu[m_g].pop_front());
          end
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
    end
  end

  task automatic clear_log();
    log_d.delete(); log_l.delete(); log_u.delete();
  endtask

  task automatic wait_drain(input int budget);
    int  n;
    bit  empty;
    n = 0;
    empty = 0;
    while (!empty && n < budget) begin
      @(posedge clk); #2;
      n++;
      empty = !m_act;
      for (int c = 0; c < NCH; c++) if (sq_d[c].size() != 0) empty = 0;
    end
    if (!empty) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: still busy after %0d cycles, required idle", budget);
    end
  endtask

  initial begin
    logic [DW-1:0] dv [4];
    int            order [9];
    bit            hit;
    order = '{4, 5, 6, 7, 0, 1, 2, 3, 0};
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Channel 3, four words, MAC always ready.
    clear_log();
    for (int i = 0; i < 4; i++) begin
      dv[i] = 64'h0123_4567_89AB_0000 + 64'(i);
      push_word(3, dv[i], (i == 3), 1'b0);
    end
    wait_drain(200);
    chk("t1_len", 64'(log_d.size()), 5);
    if (log_d.size() == 5) begin
      chk("t1_hdr", log_d[0], 64'hA503_0000_0000_0000);
      for (int i = 0; i < 4; i++) chk("t1_data", log_d[i+1], dv[i]);
      chk("t1_last3", log_l[3], 1'b0);
      chk("t1_last4", log_l[4], 1'b1);
      chk("t1_user4", log_u[4], 1'b0);
    end

    // Every channel requests at once, channel 0 twice; rotation continues after channel 3.
    clear_log();
    for (int c = 0; c < NCH; c++) push_frame(c, 2);
    push_frame(0, 2);
    wait_drain(400);
    chk("t2_len", 64'(log_d.size()), 27);
    if (log_d.size() == 27) begin
      for (int f = 0; f < 9; f++) chk("t2_grant", 64'(log_d[3*f][55:48]), 64'(order[f]));
      chk("t2_seq3", log_d[21], 64'hA503_0001_0000_0000);
      chk("t2_seq0", log_d[24], 64'hA500_0001_0000_0000);
    end

    // Channel 1 sends 7 words; only MAX_LEN=4 reach the output.
    clear_log();
    for (int i = 0; i < 7; i++) push_word(1, 64'hBEEF_0000 + 64'(i), (i == 6), 1'b0);
    wait_drain(200);
    chk("t3_len", 64'(log_d.size()), 5);
    if (log_d.size() == 5) begin
      chk("t3_data4", log_d[4], 64'hBEEF_0003);
      chk("t3_last4", log_l[4], 1'b1);
      chk("t3_user4", log_u[4], 1'b1);
    end
    chk("t3_trunc", trunc_cnt, 16'd1);

    // MAC ready toggling 1010 with back-to-back frames.
    rdy_mode = 1;
    for (int i = 0; i < 12; i++) push_frame($urandom_range(0, NCH - 1), $urandom_range(1, 7));
    wait_drain(2000);

    // Random gaps on both sides, random lengths across the truncation boundary.
    rdy_mode = 2;
    vld_pct  = 60;
    for (int i = 0; i < 40; i++) begin
      push_frame($urandom_range(0, NCH - 1), $urandom_range(1, 7));
      repeat ($urandom_range(0, 6)) @(posedge clk);
      #2;
    end
    wait_drain(5000);

    // Reset while payload word 2 of a channel 0 frame is on the output.
    rdy_mode = 0;
    vld_pct  = 100;
    push_frame(0, 4);
    hit = 0;
    for (int n = 0; n < 50 && !hit; n++) begin
      @(posedge clk); #2;
      if (m_act && !m_hdr && !m_drop && m_g == 0 && m_nout == 1) hit = 1;
    end
    chk("t5_reached_word2", 64'(hit), 1);
    rst = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      sq_d[c].delete(); sq_l[c].delete(); sq_u[c].delete();
    end
    @(posedge clk); #2;
    rst = 1'b0;
    chk("t5_busy", busy, 1'b0);
    chk("t5_valid", m_tvalid, 1'b0);
    chk("t5_trunc", trunc_cnt, 16'd0);
    clear_log();
    push_frame(0, 2);
    wait_drain(200);
    chk("t5_len", 64'(log_d.size()), 3);
    if (log_d.size() == 3) chk("t5_hdr", log_d[0], 64'hA500_0000_0000_0000);

    // Sequence wrap: 2^SW+1 one-word frames on channel 2.
    clear_log();
    for (int i = 0; i < (1 << SW) + 1; i++) push_word(2, 64'(i), 1'b1, 1'b0);
    wait_drain(2000);
    chk("t6_len", 64'(log_d.size()), 2 * ((1 << SW) + 1));
    if (log_d.size() == 2 * ((1 << SW) + 1)) begin
      chk("t6_hdr15", log_d[30], 64'hA502_000F_0000_0000);
      chk("t6_hdr_wrap", log_d[32], 64'hA502_0000_0000_0000);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
